frequency_meter: RTL and testbench

- Measures the period of an external pulse or square-wave input in system clock cycles.
- Classifies the measured period against the standard timer rates of 1, 2, 5 and 10 Hz.
- Complements the timer circuits: they generate ticks from a rate, this block recovers the rate from ticks. Used for self-check of timer outputs and for reading external beacons.
- Sits beside the timers in the same clock domain. The input may be asynchronous.

---
 rtl/definitions.sv | 46 ++++
 rtl/frequency_meter_edge_detector.sv | 32 +++
 rtl/frequency_meter.sv | 161 ++++++++++++++++
 tb/tb_frequency_meter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared types, defaults and the period classifier for frequency_meter.
// Included first; imported by the meter and its edge detector.
package definitions;

  localparam int CLOCK_FREQUENCY_HZ = 50000000;

  typedef enum logic [2:0] {
    FREQ_NONE  = 3'd0,
    FREQ_1HZ   = 3'd1,
    FREQ_2HZ   = 3'd2,
    FREQ_5HZ   = 3'd3,
    FREQ_10HZ  = 3'd4,
    FREQ_OTHER = 3'd5
  } measured_frequency_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } frequency_meter_state_t;

  function automatic logic in_band(
    logic [63:0] p,
    logic [63:0] nom,
    logic [63:0] tol
  );
    return ((p + tol) >= nom) && (p <= (nom + tol));
  endfunction

  function automatic measured_frequency_t classify_period(
    logic [63:0] p,
    logic [63:0] clk_hz,
    logic [63:0] tol
  );
    if (in_band(p, clk_hz, tol))
      return FREQ_1HZ;
    else if (in_band(p, clk_hz / 2, tol))
      return FREQ_2HZ;
    else if (in_band(p, clk_hz / 5, tol))
      return FREQ_5HZ;
    else if (in_band(p, clk_hz / 10, tol))
      return FREQ_10HZ;
    else
      return FREQ_OTHER;
  endfunction

endpackage

// File: rtl/frequency_meter_edge_detector.sv
// Two-flop synchronizer plus a registered rising-edge strobe.
// The strobe appears three clocks after signal_in rises.
module edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic signal_in,
  output logic rising_edge_out
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchronize, delay one more stage, register the rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= signal_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rising_edge_out = rise_q;

endmodule

// File: rtl/frequency_meter.sv
// Period meter with 1/2/5/10 Hz classification and timeout.
// Define FREQUENCY_METER_AVERAGE_EN to report a 4-period average.
module frequency_meter
  import definitions::*;
#(
  parameter int CLOCK_FREQUENCY_HZ = definitions::CLOCK_FREQUENCY_HZ,
  parameter int PERIOD_WIDTH       = 32,
  parameter int TOLERANCE_CYCLES   = CLOCK_FREQUENCY_HZ / 1000,
  parameter int TIMEOUT_CYCLES     = 2 * CLOCK_FREQUENCY_HZ
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    signal_in,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output measured_frequency_t     frequency_out,
  output logic                    valid_out,
  output logic                    timeout_out
);

  localparam logic [PERIOD_WIDTH-1:0] ONE =
    PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] TO_LAST =
    PERIOD_WIDTH'(TIMEOUT_CYCLES - 1);

  frequency_meter_state_t  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  measured_frequency_t     freq_q, freq_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;

  logic                    edge_seen;
  logic [PERIOD_WIDTH-1:0] meas;
  logic [PERIOD_WIDTH-1:0] rep_period;
  logic                    rep_ok;

  edge_detector u_edge (
    .clock           (clock),
    .reset_n         (reset_n),
    .signal_in       (signal_in),
    .rising_edge_out (edge_seen)
  );

  assign meas = cnt_q + ONE;

`ifdef FREQUENCY_METER_AVERAGE_EN
  logic [PERIOD_WIDTH-1:0] hist_q [3];
  logic [1:0]              nhist_q;
  logic [PERIOD_WIDTH+1:0] sum;

  // Average the new period with the three before it.
  always_comb begin
    sum = {2'b00, meas}
        + {2'b00, hist_q[0]}
        + {2'b00, hist_q[1]}
        + {2'b00, hist_q[2]};
    rep_period = sum[PERIOD_WIDTH+1:2];
    rep_ok     = (nhist_q == 2'd3);
  end

  // Period history; emptied whenever the block heads to IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
      nhist_q   <= 2'd0;
    end else if (state_d == IDLE) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
      nhist_q   <= 2'd0;
    end else if (state_q == MEASURE && edge_seen) begin
      hist_q[2] <= hist_q[1];
      hist_q[1] <= hist_q[0];
      hist_q[0] <= meas;
      if (nhist_q != 2'd3)
        nhist_q <= nhist_q + 2'd1;
    end
  end
`else
  // Single-period reporting.
  always_comb begin
    rep_period = meas;
    rep_ok     = 1'b1;
  end
`endif

  // Next state, counter and output updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    freq_d    = freq_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (edge_seen)
            state_d = MEASURE;
        end
        MEASURE: begin
          if (edge_seen) begin
            cnt_d = '0;
            if (rep_ok) begin
              period_d = rep_period;
              freq_d   = classify_period(
                64'(rep_period),
                64'(CLOCK_FREQUENCY_HZ),
                64'(TOLERANCE_CYCLES));
              valid_d  = 1'b1;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            period_d  = '0;
            freq_d    = FREQ_NONE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      freq_q    <= FREQ_NONE;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out    = period_q;
  assign frequency_out = freq_q;
  assign valid_out     = valid_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter: timestamp reference model, vector table,
// hand sequences for timeout, enable abort and async reset.
module tb_frequency_meter;
  import definitions::*;

  localparam int F   = 1000;
  localparam int TOL = 5;
  localparam int TO  = 2000;
  localparam int PW  = 32;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                signal_in;
  logic [PW-1:0]       period_out;
  measured_frequency_t frequency_out;
  logic                valid_out;
  logic                timeout_out;

  frequency_meter #(
    .CLOCK_FREQUENCY_HZ (F),
    .PERIOD_WIDTH       (PW),
    .TOLERANCE_CYCLES   (TOL),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .signal_in     (signal_in),
    .period_out    (period_out),
    .frequency_out (frequency_out),
    .valid_out     (valid_out),
    .timeout_out   (timeout_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  // reference model state (timestamps of consumed edges)
  int                  cyc;
  bit                  m_armed;
  int                  m_last;
  int                  m_per;
  measured_frequency_t m_freq;
  bit                  m_valid;
  bit                  m_to;
  bit                  m_en;
  bit                  sh[$];

  // observation
  int                  n_valid;
  int                  n_to;
  int                  last_vp;
  measured_frequency_t last_vf;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0h expected %0h at %0t",
                 name, act, exp, $time);
      end
    end
  endtask

  function automatic measured_frequency_t ref_class(int p);
    int noms[4];
    measured_frequency_t cls[4];
    noms = '{F, F / 2, F / 5, F / 10};
    cls  = '{FREQ_1HZ, FREQ_2HZ, FREQ_5HZ, FREQ_10HZ};
    for (int i = 0; i < 4; i++) begin
      int d;
      d = p - noms[i];
      if (d < 0) d = -d;
      if (d <= TOL) return cls[i];
    end
    return FREQ_OTHER;
  endfunction

  task automatic model_reset();
    m_armed = 0;
    m_last  = 0;
    m_per   = 0;
    m_freq  = FREQ_NONE;
    m_valid = 0;
    m_to    = 0;
    sh.delete();
    for (int i = 0; i < 5; i++) sh.push_back(1'b0);
  endtask

  // One clock edge of the spec: the edge reaches the core 3 cycles
  // after the input rises, so it is judged on the input 4/5 cycles back.
  task automatic model_edge();
    bit det;
    cyc++;
    det = sh[3] & ~sh[4];
    m_valid = 0;
    m_to    = 0;
    if (!m_en) begin
      m_armed = 0;
    end else if (det) begin
      if (m_armed) begin
        m_per   = cyc - m_last;
        m_freq  = ref_class(m_per);
        m_valid = 1;
      end
      m_armed = 1;
      m_last  = cyc;
    end else if (m_armed && (cyc - m_last) == TO) begin
      m_armed = 0;
      m_per   = 0;
      m_freq  = FREQ_NONE;
      m_to    = 1;
    end
  endtask

  task automatic push_sig(input bit s);
    sh.push_front(s);
    void'(sh.pop_back());
  endtask

  task automatic step(input bit en, input bit sig);
    longint act;
    longint exp;
    @(posedge clock);
    model_edge();
    #1;
    enable    = en;
    signal_in = sig;
    m_en      = en;
    push_sig(sig);
    @(negedge clock);
    act = {26'd0, valid_out, timeout_out, 3'(frequency_out), period_out};
    exp = {26'd0, m_valid, m_to, 3'(m_freq), 32'(m_per)};
    chk("cycle", act, exp);
    if (valid_out) begin
      n_valid++;
      last_vp = int'(period_out);
      last_vf = frequency_out;
    end
    if (timeout_out) n_to++;
  endtask

  task automatic square(input int p, input int nb);
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < p; i++)
        step(1'b1, i < p / 2);
  endtask

  typedef struct {
    int                  period;
    int                  exp_period;
    measured_frequency_t exp_freq;
  } vec_t;

  vec_t vt[10];

  initial begin
    int v0, t0;
    vt[0] = '{1000, 1000, FREQ_1HZ};
    vt[1] = '{200,  200,  FREQ_5HZ};
    vt[2] = '{1005, 1005, FREQ_1HZ};
    vt[3] = '{1006, 1006, FREQ_OTHER};
    vt[4] = '{95,   95,   FREQ_10HZ};
    vt[5] = '{500,  500,  FREQ_2HZ};
    vt[6] = '{494,  494,  FREQ_OTHER};
    vt[7] = '{105,  105,  FREQ_10HZ};
    vt[8] = '{196,  196,  FREQ_5HZ};
    vt[9] = '{333,  333,  FREQ_OTHER};

    cyc = 0;
    n_valid = 0;
    n_to = 0;
    last_vp = 0;
    last_vf = FREQ_NONE;
    reset_n   = 1'b0;
    enable    = 1'b0;
    signal_in = 1'b0;
    model_reset();
    #12;
    chk("rst_period", longint'(period_out), 0);
    chk("rst_freq", longint'(frequency_out), longint'(FREQ_NONE));
    chk("rst_valid", longint'(valid_out), 0);
    chk("rst_timeout", longint'(timeout_out), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    m_en    = 1'b1;
    push_sig(1'b0);

    // idle input, no pulses
    for (int i = 0; i < 3000; i++) step(1'b1, 1'b0);
    chk("idle_valid_cnt", n_valid, 0);
    chk("idle_to_cnt", n_to, 0);
    chk("idle_period", longint'(period_out), 0);
    chk("idle_freq", longint'(frequency_out), longint'(FREQ_NONE));

    // table of square-wave periods
    for (int k = 0; k < 10; k++) begin
      v0 = n_valid;
      square(vt[k].period, 2);
      chk("tbl_reported", longint'(n_valid > v0), 1);
      chk("tbl_period", last_vp, vt[k].exp_period);
      chk("tbl_freq", longint'(last_vf), longint'(vt[k].exp_freq));
    end

    // input stops: timeout, then the next edge only arms
    t0 = n_to;
    for (int i = 0; i < 2100; i++) step(1'b1, 1'b0);
    chk("to_pulses", n_to - t0, 1);
    chk("to_period", longint'(period_out), 0);
    chk("to_freq", longint'(frequency_out), longint'(FREQ_NONE));
    v0 = n_valid;
    square(600, 1);
    chk("rearm_no_valid", n_valid - v0, 0);

    // enable dropped mid-period
    square(500, 3);
    v0 = 0;
    for (int i = 0; i < 500; i++) begin
      if (i == 10) v0 = n_valid;
      step(!(i >= 300 && i < 350), i < 250);
    end
    square(500, 1);
    chk("abort_no_valid", n_valid - v0, 0);
    chk("abort_hold_period", longint'(period_out), 500);
    chk("abort_hold_freq", longint'(frequency_out), longint'(FREQ_2HZ));
    square(500, 1);
    chk("reen_count", n_valid - v0, 1);
    chk("reen_period", last_vp, 500);
    chk("reen_freq", longint'(last_vf), longint'(FREQ_2HZ));

    // asynchronous reset mid-measurement
    square(200, 2);
    for (int i = 0; i < 50; i++) step(1'b1, i < 100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_period", longint'(period_out), 0);
    chk("arst_freq", longint'(frequency_out), longint'(FREQ_NONE));
    chk("arst_valid", longint'(valid_out), 0);
    chk("arst_state", longint'(dut.state_q), longint'(IDLE));
    signal_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    m_en    = enable;
    push_sig(1'b0);
    square(1000, 2);
    chk("post_rst_period", last_vp, 1000);

    // randomized periods with occasional enable dropouts
    for (int it = 0; it < 20; it++) begin
      int sel, p, nb, a, d;
      bit drop;
      sel = int'($urandom_range(0, 4));
      unique case (sel)
        0: p = 1000 + int'($urandom_range(0, 16)) - 8;
        1: p = 500 + int'($urandom_range(0, 16)) - 8;
        2: p = 200 + int'($urandom_range(0, 16)) - 8;
        3: p = 100 + int'($urandom_range(0, 16)) - 8;
        default: p = int'($urandom_range(20, 2300));
      endcase
      nb   = int'($urandom_range(1, 2));
      drop = ($urandom_range(0, 4) == 0);
      a    = int'($urandom_range(0, p - 1));
      d    = int'($urandom_range(1, 60));
      for (int b = 0; b < nb; b++)
        for (int i = 0; i < p; i++)
          step(!(drop && b == 0 && i >= a && i < a + d), i < p / 2);
    end
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
